// File: rtl/cpu_controller_hs.sv
// Multicycle control FSM for the 16-bit datapath with ready/ack memory handshake,
// wait-state timeout, illegal-opcode trap and conditional jump/branch resolution.
module cpu_controller_hs #(
  parameter int WIDTH       = 16,
  parameter int REGBITS     = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        mem_rdata,
  input  logic               mem_ack,
  input  logic               cond_true,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic [REGBITS-1:0] reg_a,
  output logic [REGBITS-1:0] reg_b,
  output logic [WIDTH-1:0]   immediate,
  output logic [3:0]         cond_code,
  output logic [3:0]         alu_op,
  output logic [1:0]         shift_op,
  output logic [2:0]         bus_op,
  output logic               imm_mux,
  output logic               reg_write,
  output logic               flag_write,
  output logic               pc_add,
  output logic               pc_jump,
  output logic               pc_branch,
  output logic               illegal,
  output logic               bus_err
);

  typedef enum logic [2:0] {S_FETCH, S_RETRY, S_DECODE, S_EXEC, S_MEM, S_LINK, S_BRANCH} state_t;
  typedef enum logic [2:0] {K_ALU, K_LOAD, K_STOR, K_JAL, K_JCOND, K_BCOND, K_ILL} kind_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CW-1:0] TO_V = CW'(MEM_TIMEOUT);

  state_t          state;
  kind_t           kind_q, d_kind;
  logic [15:0]     ir;
  logic [CW-1:0]   cnt;
  logic [3:0]      alu_q, d_alu, a_op, code, op_hi, ext, d_cond;
  logic [2:0]      bus_q, d_bus, a_bus;
  logic            immx_q, rw_q, fw_q, d_immx, d_rw, d_fw, a_ok, a_rw, a_fw, tmo;
  logic [WIDTH-1:0] d_imm, sext8, zext8, sext5;

  assign op_hi    = ir[15:12];
  assign ext      = ir[7:4];
  assign sext8    = {{(WIDTH-8){ir[7]}}, ir[7:0]};
  assign zext8    = {{(WIDTH-8){1'b0}}, ir[7:0]};
  assign sext5    = {{(WIDTH-5){ir[4]}}, ir[4:0]};
  assign tmo      = (MEM_TIMEOUT != 0) && (cnt == TO_V);
  assign shift_op = 2'b00;

  // R-type carries the ALU code in ext, I-type carries the same code in op_hi.
  always_comb begin
    code  = (op_hi == 4'h0) ? ext : op_hi;
    a_ok  = 1'b1;
    a_op  = 4'h0;
    a_bus = 3'b000;
    a_rw  = (code != 4'hB);
    a_fw  = 1'b1;
    case (code)
      4'h5: ;
      4'h9, 4'hB: a_op = 4'h8;
      4'h1, 4'h2, 4'h3: a_op = code;
      4'hD: begin a_bus = 3'b010; a_fw = 1'b0; end
      default: a_ok = 1'b0;
    endcase
    d_kind = K_ILL; d_alu = 4'h0; d_bus = 3'b000; d_immx = 1'b0;
    d_rw = 1'b0; d_fw = 1'b0; d_imm = '0; d_cond = 4'h0;
    if (a_ok) begin
      d_kind = K_ALU; d_alu = a_op; d_bus = a_bus; d_rw = a_rw; d_fw = a_fw;
      if (op_hi != 4'h0) begin
        d_immx = 1'b1;
        d_imm  = (code == 4'h5 || code == 4'h9 || code == 4'hB) ? sext8 : zext8;
      end
    end else begin
      case (op_hi)
        4'h8: if (ext == 4'h4) begin
                d_kind = K_ALU; d_bus = 3'b001; d_rw = 1'b1;
              end else if (ext[3:1] == 3'b000) begin
                d_kind = K_ALU; d_bus = 3'b001; d_rw = 1'b1; d_immx = 1'b1; d_imm = sext5;
              end
        4'hF: begin d_kind = K_ALU; d_bus = 3'b101; d_rw = 1'b1; d_imm = zext8; end
        4'h4: case (ext)
                4'h0: d_kind = K_LOAD;
                4'h4: d_kind = K_STOR;
                4'h8: d_kind = K_JAL;
                4'hC: begin d_kind = K_JCOND; d_cond = ir[11:8]; end
                default: ;
              endcase
        4'hC: begin d_kind = K_BCOND; d_imm = sext8; d_cond = ir[11:8]; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH; ir <= '0; cnt <= '0; kind_q <= K_ALU;
      alu_q <= '0; bus_q <= '0; immx_q <= 1'b0; rw_q <= 1'b0; fw_q <= 1'b0;
      reg_a <= '0; reg_b <= '0; immediate <= '0; cond_code <= '0;
    end else begin
      case (state)
        S_FETCH:
          if (mem_ack) begin ir <= mem_rdata; cnt <= '0; state <= S_DECODE; end
          else if (tmo) begin cnt <= '0; state <= S_RETRY; end
          else cnt <= cnt + 1'b1;
        S_RETRY: state <= S_FETCH;
        S_DECODE: begin
          kind_q <= d_kind; alu_q <= d_alu; bus_q <= d_bus; immx_q <= d_immx;
          rw_q <= d_rw; fw_q <= d_fw; immediate <= d_imm; cond_code <= d_cond;
          reg_a <= ir[REGBITS-1:0]; reg_b <= ir[8 +: REGBITS];
          case (d_kind)
            K_ALU:           state <= S_EXEC;
            K_LOAD, K_STOR:  state <= S_MEM;
            K_JAL:           state <= S_LINK;
            K_JCOND, K_BCOND: state <= S_BRANCH;
            default:         state <= S_FETCH;
          endcase
        end
        S_EXEC: state <= S_FETCH;
        S_MEM:
          if (mem_ack || tmo) begin cnt <= '0; state <= S_FETCH; end
          else cnt <= cnt + 1'b1;
        S_LINK:   state <= S_BRANCH;
        S_BRANCH: state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Strobes are decoded from the registered state; held low throughout reset.
  always_comb begin
    mem_req = 1'b0; mem_we = 1'b0; mem_addr_sel = 1'b0; alu_op = 4'h0; bus_op = 3'b000;
    imm_mux = 1'b0; reg_write = 1'b0; flag_write = 1'b0; pc_add = 1'b0; pc_jump = 1'b0;
    pc_branch = 1'b0; illegal = 1'b0; bus_err = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin mem_req = 1'b1; bus_err = !mem_ack && tmo; end
        S_DECODE: if (d_kind == K_ILL) begin illegal = 1'b1; pc_add = 1'b1; end
        S_EXEC: begin
          reg_write = rw_q; flag_write = fw_q; pc_add = 1'b1;
          alu_op = alu_q; bus_op = bus_q; imm_mux = immx_q;
        end
        S_MEM: begin
          mem_req = 1'b1; mem_addr_sel = 1'b1; mem_we = (kind_q == K_STOR);
          if (mem_ack) begin
            pc_add = 1'b1;
            if (kind_q == K_LOAD) begin reg_write = 1'b1; bus_op = 3'b011; end
          end else if (tmo) begin
            bus_err = 1'b1; pc_add = 1'b1;
          end
        end
        S_LINK: begin reg_write = 1'b1; bus_op = 3'b100; end
        S_BRANCH:
          if (kind_q == K_JAL || cond_true) begin
            if (kind_q == K_BCOND) begin pc_branch = 1'b1; imm_mux = 1'b1; end
            else pc_jump = 1'b1;
          end else pc_add = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
